// File: rtl/soc_system_pll_ctrl_pkg.sv
// PLL lock sequencer: shared state encoding and counter sizing helper.
package soc_system_pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_e;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/soc_system_pll_ctrl_sync.sv
// Two-flop synchronizer, both flops cleared by reset.
module soc_system_pll_ctrl_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic ff1_q;
    logic ff2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
        end else begin
            ff1_q <= d_i;
            ff2_q <= ff1_q;
        end
    end

    assign q_o = ff2_q;

endmodule

// File: rtl/soc_system_pll_ctrl.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a stable
// lock with bounded retries, then releases the downstream system reset.
module soc_system_pll_ctrl #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       req_restart,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       clk_ready,
    output logic       fail,
    output logic [2:0] state,
    output logic [1:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    import soc_system_pll_ctrl_pkg::*;

    localparam int PW = cnt_w(RST_PULSE_CYCLES);
    localparam int TW = cnt_w(LOCK_TIMEOUT_CYCLES);
    localparam int SW = cnt_w(LOCK_STABLE_CYCLES);

    localparam logic [PW-1:0] PLAST = PW'(RST_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] TLAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] SLAST = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [1:0]    RMAX  = 2'(MAX_RETRIES);

    logic locked_s;

    state_e        state_q, state_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [1:0]    retry_q, retry_d;
    logic [7:0]    loss_q, loss_d;
    logic          pll_rst_q, pll_rst_d;
    logic          sys_rst_q, sys_rst_d;
    logic          clk_ready_q, clk_ready_d;
    logic          fail_q, fail_d;

    soc_system_pll_ctrl_sync u_lock_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (pll_locked),
        .q_o   (locked_s)
    );

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        tmr_d   = tmr_q;
        stab_d  = stab_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        unique case (state_q)
            ST_RESET_PLL: begin
                if (pcnt_q == PLAST) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = ST_STABILIZE;
                end else if (tmr_q == TLAST) begin
                    if (retry_q == RMAX) begin
                        state_d = ST_FAIL;
                    end else begin
                        retry_d = retry_q + 2'd1;
                        state_d = ST_RESET_PLL;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_STABILIZE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (stab_q == SLAST) begin
                    state_d = ST_RUN;
                    retry_d = 2'd0;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    if (loss_q != 8'hFF) begin
                        loss_d = loss_q + 8'd1;
                    end
                    retry_d = 2'd0;
                    state_d = ST_RESET_PLL;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_RESET_PLL;
            end
        endcase

        // Restart wins over every transition above but keeps the loss count.
        if (req_restart) begin
            state_d = ST_RESET_PLL;
            retry_d = 2'd0;
        end

        if (req_restart || (state_d != state_q)) begin
            pcnt_d = '0;
            tmr_d  = '0;
            stab_d = '0;
        end

        pll_rst_d   = (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
        sys_rst_d   = (state_d != ST_RUN);
        clk_ready_d = (state_d == ST_RUN);
        fail_d      = (state_d == ST_FAIL);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RESET_PLL;
            pcnt_q      <= '0;
            tmr_q       <= '0;
            stab_q      <= '0;
            retry_q     <= 2'd0;
            loss_q      <= 8'd0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            clk_ready_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pcnt_q      <= pcnt_d;
            tmr_q       <= tmr_d;
            stab_q      <= stab_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_q   <= sys_rst_d;
            clk_ready_q <= clk_ready_d;
            fail_q      <= fail_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign sys_rst       = sys_rst_q;
    assign clk_ready     = clk_ready_q;
    assign fail          = fail_q;
    assign state         = state_q;
    assign retry_cnt     = retry_q;
    assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_soc_system_pll_ctrl.sv
// Directed bench for the PLL lock sequencer with an expectation queue.
module tb_soc_system_pll_ctrl;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       req_restart = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       clk_ready;
    logic       fail;
    logic [2:0] state;
    logic [1:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   n;
    int   m;

    soc_system_pll_ctrl #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES (20),
        .LOCK_STABLE_CYCLES  (8),
        .MAX_RETRIES         (2)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .req_restart   (req_restart),
        .pll_rst       (pll_rst),
        .sys_rst       (sys_rst),
        .clk_ready     (clk_ready),
        .fail          (fail),
        .state         (state),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 refclk = ~refclk;

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL sb_empty: got %0d, no expectation queued", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                fails++;
                $error("FAIL %s: got %0d required %0d", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        push(tag, exp);
        pop_cmp(obs);
    endtask

    task automatic wait_st(input string tag, input logic [2:0] tgt,
                           input int max, output int cnt);
        push(tag, {29'd0, tgt});
        cnt = 0;
        while (state !== tgt && cnt < max) begin
            tick();
            cnt++;
        end
        pop_cmp({29'd0, state});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_state"}, {29'd0, state}, 0);
        chk({tag, "_pll_rst"}, {31'd0, pll_rst}, 1);
        chk({tag, "_sys_rst"}, {31'd0, sys_rst}, 1);
        chk({tag, "_clk_ready"}, {31'd0, clk_ready}, 0);
        chk({tag, "_fail"}, {31'd0, fail}, 0);
        chk({tag, "_retry"}, {30'd0, retry_cnt}, 0);
        chk({tag, "_loss"}, {24'd0, lock_loss_cnt}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        chk_reset("por");

        // Bring-up: pulse length, sync latency, stabilize length
        rst = 1'b0;
        n = 0;
        while (pll_rst && n < 100) begin
            tick();
            n++;
        end
        chk("pll_rst_pulse", n, 4);
        chk("wait_lock_entry", {29'd0, state}, 1);
        repeat (5) tick();
        pll_locked = 1'b1;
        wait_st("to_stabilize", 3'd2, 50, n);
        chk("stab_latency", n, 3);
        wait_st("to_run", 3'd3, 50, n);
        chk("run_latency", n, 8);
        chk("run_clk_ready", {31'd0, clk_ready}, 1);
        chk("run_sys_rst", {31'd0, sys_rst}, 0);
        chk("run_pll_rst", {31'd0, pll_rst}, 0);

        // One-cycle lock loss in RUN
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        wait_st("loss_to_reset", 3'd0, 10, m);
        chk("loss_latency", m + 1, 3);
        chk("loss_cnt_1", {24'd0, lock_loss_cnt}, 1);
        chk("loss_sys_rst", {31'd0, sys_rst}, 1);
        chk("loss_clk_ready", {31'd0, clk_ready}, 0);
        wait_st("rerun", 3'd3, 100, n);
        chk("rerun_loss_cnt", {24'd0, lock_loss_cnt}, 1);

        // Restart from RUN, then glitch at stable count 5
        req_restart = 1'b1;
        push("restart_state", 0);
        tick();
        req_restart = 1'b0;
        pop_cmp({29'd0, state});
        wait_st("stab2", 3'd2, 100, n);
        repeat (3) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        chk("glitch_still_stab", {29'd0, state}, 2);
        tick();
        chk("glitch_wait_lock", {29'd0, state}, 1);
        chk("glitch_clk_ready", {31'd0, clk_ready}, 0);
        chk("glitch_retry", {30'd0, retry_cnt}, 0);
        wait_st("run_after_glitch", 3'd3, 100, n);
        chk("glitch_loss_cnt", {24'd0, lock_loss_cnt}, 1);

        // Lock loss coinciding with restart still counts
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        req_restart = 1'b1;
        push("coinc_state", 0);
        push("coinc_loss", 2);
        tick();
        req_restart = 1'b0;
        pop_cmp({29'd0, state});
        pop_cmp({24'd0, lock_loss_cnt});

        // Permanent loss of lock: retries then FAIL
        wait_st("run3", 3'd3, 100, n);
        pll_locked = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_st("retry_reset", 3'd0, 30, n);
            chk("retry_cnt", {30'd0, retry_cnt}, i);
            wait_st("retry_wait", 3'd1, 30, n);
            m = 0;
            while (state === 3'd1 && m < 50) begin
                tick();
                m++;
            end
            chk("timeout_len", m, 20);
        end
        chk("fail_state", {29'd0, state}, 4);
        chk("fail_flag", {31'd0, fail}, 1);
        chk("fail_pll_rst", {31'd0, pll_rst}, 1);
        chk("fail_sys_rst", {31'd0, sys_rst}, 1);
        chk("fail_clk_ready", {31'd0, clk_ready}, 0);
        chk("fail_retry", {30'd0, retry_cnt}, 2);
        chk("fail_loss", {24'd0, lock_loss_cnt}, 3);
        repeat (5) tick();
        chk("fail_held", {29'd0, state}, 4);

        // Restart out of FAIL, then async reset mid WAIT_LOCK
        req_restart = 1'b1;
        push("rs_fail", 0);
        push("rs_state", 0);
        push("rs_retry", 0);
        tick();
        req_restart = 1'b0;
        pop_cmp({31'd0, fail});
        pop_cmp({29'd0, state});
        pop_cmp({30'd0, retry_cnt});
        wait_st("wait3", 3'd1, 20, n);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk_reset("async");
        tick();
        chk_reset("held");
        rst = 1'b0;

        // Saturation of the lock-loss counter
        pll_locked = 1'b1;
        for (int k = 0; k < 256; k++) begin
            wait_st("sat_run", 3'd3, 100, n);
            if (state !== 3'd3) break;
            pll_locked = 1'b0;
            tick();
            pll_locked = 1'b1;
            wait_st("sat_reset", 3'd0, 10, n);
            if (k == 254) chk("loss_255", {24'd0, lock_loss_cnt}, 255);
        end
        chk("loss_sat", {24'd0, lock_loss_cnt}, 255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
